matmul_ctrl: RTL and testbench
==============================

// Module: matmul_ctrl
// PURPOSE
//  Sequencer for the 4-row MAC ALU. It loads one 4x8-byte input matrix into the X buffer over a
//  valid/ready stream, then enables the ALU for one full 32-cycle pass. It captures the four MU
//  partial sums each time the ALU flags a finished column and writes them to the result RAM.
//  One matrix per start; sits between the host-side input stream and the ALU/result RAM.
// PARAMETERS
//  IN_W        32  input stream word width (bits)
//  LOAD_WORDS  8   words per matrix (2 per 64-bit X row)
//  MU_W        18  ALU MU accumulator width
//  N_COL       4   result columns per pass (one per ALU web pulse)
// PORTS
//  clk        in   1     clock, all state on rising edge
//  rst        in   1     asynchronous reset, active-low
//  start      in   1     1-cycle pulse in IDLE: begin a matrix
//  in_valid   in   1     input word valid
//  in_ready   out  1     controller accepts in_data
//  in_data    in   IN_W  input matrix word
//  buf_we     out  1     X buffer write strobe
//  buf_waddr  out  3     X buffer word address (row = addr[2:1], half = addr[0])
//  buf_wdata  out  IN_W  registered copy of in_data
//  alu_en     out  1     ALU_en drive
//  alu_web    in   1     ALU web: column finished, MU final on the following cycle
//  alu_done   in   1     ALU_done: last column of pass
//  mu1..mu4   in   MU_W  ALU MU1..MU4
//  ram_we     out  1     result RAM write enable
//  ram_addr   out  4     {col[1:0], row[1:0]}
//  ram_wdata  out  MU_W  result value
//  busy       out  1     high in any state except IDLE
//  done       out  1     1-cycle pulse: all 16 results written
// BEHAVIOUR
//  Reset: all outputs 0. State = IDLE. Counters and holding registers = 0.
//  FSM states: IDLE, LOAD, RUN, DRAIN, DONE.
//   IDLE -> LOAD on start. start is ignored outside IDLE.
//   LOAD: in_ready=1. Each in_valid&in_ready handshake produces buf_we=1 on the next cycle,
//     with buf_waddr = word index and buf_wdata = data. After word 7 -> RUN.
//     in_valid low stalls the load indefinitely.
//   RUN: alu_en=1, registered. When alu_done is sampled high, alu_en=0 the next cycle -> DRAIN.
//     Exactly 32 alu_en cycles per pass.
//   DRAIN: wait until the last column's 4 writes complete -> DONE. DONE: done=1 for one cycle -> IDLE.
//  Capture: alu_web sampled high sets cap_pend. On the next cycle, hold[0..3] <= mu1..mu4 and
//   col advances. The next 4 cycles each assert ram_we with row 0..3, ram_addr={col,row},
//   ram_wdata=hold[row]. The writer finishes in 4 cycles; the next web arrives >=8 cycles later,
//   so captures never overlap. A web with a capture or write still pending is a protocol error.
//   Debug builds assert on it; RTL behaviour for that case is undefined.
//  col wraps 3->0 and is cleared in IDLE. Results pass through unmodified (no truncation).
//  alu_web/alu_done seen outside RUN: ignored.
//  Reset mid-operation: immediately returns to IDLE with all outputs 0. Partial RAM contents are
//   not cleared.
//  Latency: start -> first in_ready 1 cycle. Last load word -> alu_en 1 cycle.
//   alu_done -> done = 6 cycles.
// CONFIGURATION
//  MATMUL_CTRL_CNT_EN defined: adds output mat_count[15:0], a wrapping count of DONE pulses
//   (reset 0, +1 per done, 16'hFFFF -> 0).
//  Not defined: the port and counter are absent. All other behaviour is identical.
// STRUCTURE
//  Package matmul_pkg: FSM state enum, IN_W/MU_W/LOAD_WORDS/N_COL constants,
//   ram address field widths.
//  Sub-module matmul_res_wr: capture plus 4-beat RAM serializer.
//   Inputs: web, mu1..4. Outputs: ram_*, idle.
//  Top holds the FSM, load counter, alu_en and busy/done.
// TESTING
//  1 Reset mid-RUN (rst low 1 cycle) -> alu_en=0, busy=0, ram_we=0 on the same cycle; the next
//    start runs a full clean pass.
//  2 start, 8 words 0x01020304.. back-to-back -> buf_we on 8 consecutive cycles, addr 0..7,
//    alu_en high on the cycle after word 7.
//  3 in_valid toggling every other cycle -> load takes 16 cycles, addresses contiguous,
//    no duplicated or dropped words.
//  4 ALU model with all-ones X and coefficient 1 -> 16 RAM writes at addr 0..15, each value 8;
//    done 6 cycles after alu_done.
//  5 start pulses during LOAD/RUN -> ignored (a single pass, exactly 16 writes).
//  6 With MATMUL_CTRL_CNT_EN, 3 back-to-back matrices -> mat_count = 3; force the counter to
//    16'hFFFF, run one pass -> 0.

Source files
------------

// File: rtl/matmul_pkg.sv
// Shared types and sizing for the MAC-ALU sequencer: FSM states, stream/accumulator widths,
// X buffer and result RAM address field widths.
package matmul_pkg;

    localparam int IN_W       = 32;
    localparam int LOAD_WORDS = 8;
    localparam int MU_W       = 18;
    localparam int N_COL      = 4;
    localparam int N_ROW      = 4;

    localparam int WADDR_W = $clog2(LOAD_WORDS);
    localparam int COL_W   = $clog2(N_COL);
    localparam int ROW_W   = $clog2(N_ROW);
    localparam int RADDR_W = COL_W + ROW_W;

    localparam logic [WADDR_W-1:0] LAST_WORD = WADDR_W'(LOAD_WORDS - 1);
    localparam logic [ROW_W-1:0]   LAST_ROW  = ROW_W'(N_ROW - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;

endpackage

// File: rtl/matmul_res_wr.sv
// Result capture: latches MU1..MU4 the cycle after an ALU column-finished pulse and
// serialises them into four result RAM writes at {col,row}.
module matmul_res_wr
    import matmul_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               web,
    input  logic [MU_W-1:0]    mu1,
    input  logic [MU_W-1:0]    mu2,
    input  logic [MU_W-1:0]    mu3,
    input  logic [MU_W-1:0]    mu4,
    output logic               ram_we,
    output logic [RADDR_W-1:0] ram_addr,
    output logic [MU_W-1:0]    ram_wdata,
    output logic               idle
);

    logic                  cap_pend_p0;
    logic [MU_W-1:0]       hold_p1 [N_ROW];
    logic                  wr_act_p1;
    logic [ROW_W-1:0]      row_p1;
    logic [COL_W-1:0]      wr_col_p1;
    logic [COL_W-1:0]      col;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cap_pend_p0 <= 1'b0;
            wr_act_p1   <= 1'b0;
            row_p1      <= '0;
            wr_col_p1   <= '0;
            col         <= '0;
            for (int i = 0; i < N_ROW; i++) hold_p1[i] <= '0;
        end else begin
            // stage 0: web seen, MU values settle during the following cycle
            cap_pend_p0 <= web;
            // stage 1: capture, then one RAM beat per row
            if (cap_pend_p0) begin
                hold_p1[0] <= mu1;
                hold_p1[1] <= mu2;
                hold_p1[2] <= mu3;
                hold_p1[3] <= mu4;
                wr_act_p1  <= 1'b1;
                row_p1     <= '0;
                wr_col_p1  <= col;
                col        <= col + 1'b1;
            end else if (wr_act_p1) begin
                if (row_p1 == LAST_ROW) wr_act_p1 <= 1'b0;
                row_p1 <= row_p1 + 1'b1;
            end
            if (clr) col <= '0;
        end
    end

    assign ram_we    = wr_act_p1;
    assign ram_addr  = wr_act_p1 ? {wr_col_p1, row_p1} : '0;
    assign ram_wdata = wr_act_p1 ? hold_p1[row_p1] : '0;

    // High already on the final beat so the sequencer can leave DRAIN without a bubble.
    assign idle = !cap_pend_p0 && (!wr_act_p1 || row_p1 == LAST_ROW);

`ifndef SYNTHESIS
    web_overlap_a: assert property (@(posedge clk) disable iff (!rst)
        !(web && (cap_pend_p0 || wr_act_p1)));
`endif

endmodule

// File: rtl/matmul_ctrl.sv
// Sequencer for the 4-row MAC ALU: loads one 8-word matrix, runs one ALU pass, drains results.
// Optional MATMUL_CTRL_CNT_EN adds mat_count, a wrapping count of completed matrices.
module matmul_ctrl
    import matmul_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [IN_W-1:0]    in_data,
    output logic               buf_we,
    output logic [WADDR_W-1:0] buf_waddr,
    output logic [IN_W-1:0]    buf_wdata,
    output logic               alu_en,
    input  logic               alu_web,
    input  logic               alu_done,
    input  logic [MU_W-1:0]    mu1,
    input  logic [MU_W-1:0]    mu2,
    input  logic [MU_W-1:0]    mu3,
    input  logic [MU_W-1:0]    mu4,
    output logic               ram_we,
    output logic [RADDR_W-1:0] ram_addr,
    output logic [MU_W-1:0]    ram_wdata,
    output logic               busy,
    output logic               done
`ifdef MATMUL_CTRL_CNT_EN
    ,
    output logic [15:0]        mat_count
`endif
);

    state_t               state;
    state_t               state_nxt;
    logic [WADDR_W-1:0]   load_cnt;
    logic                 xfer;
    logic                 wr_idle;

    assign xfer = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) state_nxt = ST_LOAD;
            end
            ST_LOAD: begin
                in_ready = 1'b1;
                if (in_valid && load_cnt == LAST_WORD) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (alu_done) state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (wr_idle) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            buf_we    <= 1'b0;
            buf_waddr <= '0;
            buf_wdata <= '0;
            load_cnt  <= '0;
            alu_en    <= 1'b0;
        end else begin
            // p1: accepted word goes to the X buffer one cycle after the handshake
            buf_we <= xfer;
            if (xfer) begin
                buf_waddr <= load_cnt;
                buf_wdata <= in_data;
                load_cnt  <= load_cnt + 1'b1;
            end
            if (state == ST_IDLE) load_cnt <= '0;
            alu_en <= (state_nxt == ST_RUN);
        end
    end

    matmul_res_wr u_res_wr (
        .clk       (clk),
        .rst       (rst),
        .clr       (state == ST_IDLE),
        .web       (alu_web && state == ST_RUN),
        .mu1       (mu1),
        .mu2       (mu2),
        .mu3       (mu3),
        .mu4       (mu4),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .idle      (wr_idle)
    );

`ifdef MATMUL_CTRL_CNT_EN
    logic [15:0] mat_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                 mat_cnt <= '0;
        else if (state == ST_DONE) mat_cnt <= mat_cnt + 16'd1;
    end

    assign mat_count = mat_cnt;
`endif

endmodule

// File: tb/tb_matmul_ctrl.sv
// Bench for matmul_ctrl: table of load/pass scenarios, ALU stand-in, scoreboards for
// X buffer and result RAM writes, plus reset-mid-pass and optional counter sequences.
module tb_matmul_ctrl;
    import matmul_pkg::*;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               start = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [IN_W-1:0]    in_data = '0;
    logic               buf_we;
    logic [WADDR_W-1:0] buf_waddr;
    logic [IN_W-1:0]    buf_wdata;
    logic               alu_en;
    logic               alu_web = 1'b0;
    logic               alu_done = 1'b0;
    logic [MU_W-1:0]    mu1 = '0, mu2 = '0, mu3 = '0, mu4 = '0;
    logic               ram_we;
    logic [RADDR_W-1:0] ram_addr;
    logic [MU_W-1:0]    ram_wdata;
    logic               busy;
    logic               done;
`ifdef MATMUL_CTRL_CNT_EN
    logic [15:0]        mat_count;
`endif

    matmul_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .buf_we    (buf_we),
        .buf_waddr (buf_waddr),
        .buf_wdata (buf_wdata),
        .alu_en    (alu_en),
        .alu_web   (alu_web),
        .alu_done  (alu_done),
        .mu1       (mu1),
        .mu2       (mu2),
        .mu3       (mu3),
        .mu4       (mu4),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .busy      (busy),
        .done      (done)
`ifdef MATMUL_CTRL_CNT_EN
        ,
        .mat_count (mat_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct { logic [WADDR_W-1:0] addr; logic [IN_W-1:0] data; } bw_t;
    typedef struct { logic [RADDR_W-1:0] addr; logic [MU_W-1:0] data; } rw_t;
    typedef struct { int gap; int pat; int spam; int span; } vec_t;

    bw_t bq[$];
    rw_t rq[$];
    bw_t be;
    rw_t re;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc = 0, nwr = 0, nen = 0, nbuf = 0, buf_first = -1, buf_last = -1;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (rst) begin
            if (alu_en) nen++;
            if (buf_we) begin
                nbuf++;
                if (buf_first < 0) buf_first = cyc;
                buf_last = cyc;
                if (bq.size() == 0) check("buf_unexpected", 1, 0);
                else begin
                    be = bq.pop_front();
                    check("buf_waddr", int'(buf_waddr), int'(be.addr));
                    check("buf_wdata", int'(buf_wdata), int'(be.data));
                end
            end
            if (ram_we) begin
                nwr++;
                if (rq.size() == 0) check("ram_unexpected", 1, 0);
                else begin
                    re = rq.pop_front();
                    check("ram_addr", int'(ram_addr), int'(re.addr));
                    check("ram_wdata", int'(ram_wdata), int'(re.data));
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [IN_W-1:0] word(input int w);
        logic [7:0] b;
        b = 8'(4 * w + 1);
        return {b, b + 8'd1, b + 8'd2, b + 8'd3};
    endfunction

    // pat 0: all-ones X times coefficient 1 gives 8 everywhere; pat 1: unique per cell, MSB set
    function automatic logic [MU_W-1:0] mu_val(input int pat, input int col, input int r);
        if (pat == 0) return MU_W'(8);
        return MU_W'(32'h20000 | (col << 8) | (r << 4) | ((col ^ r) & 3));
    endfunction

    task automatic set_mu(input int col, input int pat, input bit junk);
        logic [MU_W-1:0] m [4];
        for (int r = 0; r < 4; r++) m[r] = junk ? ~mu_val(pat, col, r) : mu_val(pat, col, r);
        mu1 = m[0]; mu2 = m[1]; mu3 = m[2]; mu4 = m[3];
    endtask

    task automatic load_matrix(input int gap, input int spam);
        int t;
        for (int w = 0; w < LOAD_WORDS; w++) begin
            in_valid = 1'b1;
            in_data  = word(w);
            start    = (spam != 0 && w == 3);
            t = 0;
            while (!in_ready && t < 50) begin
                step();
                t++;
            end
            if (t >= 50) begin
                check("load_timeout", t, 0);
                in_valid = 1'b0;
                start = 1'b0;
                return;
            end
            bq.push_back('{addr: WADDR_W'(w), data: word(w)});
            step();
            in_valid = 1'b0;
            start    = 1'b0;
            if (gap != 0 && w < LOAD_WORDS - 1) step();
        end
    endtask

    // One ALU cycle: column k/8 finishes at k%8==7, its MU values are final one cycle later
    task automatic alu_step(input int k, input int pat, input int spam);
        alu_web  = (k % 8 == 7);
        alu_done = (k == 31);
        start    = (spam != 0 && (k == 3 || k == 20));
        if (k % 8 == 7) begin
            set_mu(k / 8, pat, 1'b1);
            for (int r = 0; r < 4; r++)
                rq.push_back('{addr: RADDR_W'((k / 8) * 4 + r), data: mu_val(pat, k / 8, r)});
        end else if (k % 8 == 0 && k > 0) begin
            set_mu(k / 8 - 1, pat, 1'b0);
        end
        step();
    endtask

    task automatic do_pass(input int gap, input int pat, input int spam, input int span);
        int first;
        int t;
        nwr = 0; nen = 0; nbuf = 0; buf_first = -1; buf_last = -1;
        start = 1'b1;
        step();
        start = 1'b0;
        check("in_ready_latency", int'(in_ready), 1);
        check("busy_in_load", int'(busy), 1);
        load_matrix(gap, spam);
        check("buf_we_last_word", int'(buf_we), 1);
        check("alu_en_after_load", int'(alu_en), 1);
        check("in_ready_after_load", int'(in_ready), 0);
        for (int k = 0; k < 32; k++) alu_step(k, pat, spam);
        set_mu(3, pat, 1'b0);
        alu_web = 1'b0; alu_done = 1'b0; start = 1'b0;
        check("alu_en_off", int'(alu_en), 0);
        first = 0;
        for (int i = 1; i <= 8; i++) begin
            if (done && first == 0) first = i;
            step();
        end
        check("done_latency", first, 6);
        check("alu_en_cycles", nen, 32);
        check("ram_writes", nwr, 16);
        check("buf_writes", nbuf, 8);
        check("buf_span", buf_last - buf_first, span);
        check("ram_queue_left", rq.size(), 0);
        check("busy_after_done", int'(busy), 0);
        t = 0;
        while (rq.size() != 0 && t < 1) begin rq.delete(); t++; end
        bq.delete();
    endtask

    vec_t vecs[3];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
        $fatal(1);
    end

    initial begin
        vecs[0] = '{gap: 0, pat: 0, spam: 0, span: 7};
        vecs[1] = '{gap: 1, pat: 1, spam: 0, span: 14};
        vecs[2] = '{gap: 0, pat: 1, spam: 1, span: 7};

        step();
        step();
        check("rst_alu_en", int'(alu_en), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_in_ready", int'(in_ready), 0);
        check("rst_buf_we", int'(buf_we), 0);
        check("rst_ram_we", int'(ram_we), 0);
        check("rst_done", int'(done), 0);
        check("rst_ram_addr", int'(ram_addr), 0);
        rst = 1'b1;
        step();
        check("idle_busy", int'(busy), 0);

        // Reset while column 0 is being written
        start = 1'b1;
        step();
        start = 1'b0;
        load_matrix(0, 0);
        for (int k = 0; k < 10; k++) alu_step(k, 1, 0);
        set_mu(0, 1, 1'b0);
        alu_web = 1'b0;
        check("ram_we_inflight", int'(ram_we), 1);
        rst = 1'b0;
        #1;
        check("rstmid_alu_en", int'(alu_en), 0);
        check("rstmid_busy", int'(busy), 0);
        check("rstmid_ram_we", int'(ram_we), 0);
        check("rstmid_in_ready", int'(in_ready), 0);
        rq.delete();
        bq.delete();
        @(posedge clk);
        #1;
        rst = 1'b1;
        step();
        check("rstmid_idle", int'(busy), 0);

        for (int v = 0; v < 3; v++) do_pass(vecs[v].gap, vecs[v].pat, vecs[v].spam, vecs[v].span);

`ifdef MATMUL_CTRL_CNT_EN
        rst = 1'b0;
        step();
        rst = 1'b1;
        step();
        check("cnt_reset", int'(mat_count), 0);
        for (int p = 0; p < 3; p++) do_pass(0, 1, 0, 7);
        check("cnt_three", int'(mat_count), 3);
        force dut.mat_cnt = 16'hFFFF;
        step();
        release dut.mat_cnt;
        do_pass(0, 0, 0, 7);
        check("cnt_wrap", int'(mat_count), 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
